// File: rtl/rv_debugger_pkg.sv
// Shared encodings for the rv_debugger debug controller: opcodes, control codes,
// error words and the command-sequencer state type.
package rv_debugger_pkg;

  localparam logic [6:0]  OPC_CTRL   = 7'h0B;
  localparam logic [6:0]  REG_FUNCT  = 7'b0000001;

  localparam logic [3:0]  CMD_NOP    = 4'd0;
  localparam logic [3:0]  CMD_RESET  = 4'd1;
  localparam logic [3:0]  CMD_RESUME = 4'd2;
  localparam logic [3:0]  CMD_HALT   = 4'd3;

  localparam logic [31:0] ERR_ILLEGAL = 32'hFFFF_FFFF;
  localparam logic [31:0] ERR_TIMEOUT = 32'hFFFF_FFFE;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    DRIVE,
    WAIT,
    PUSH,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/rv_debugger_if.sv
// Host/core handshake bundle of the debug controller; the shared core port
// stays a separate inout on the top module.
interface rv_debugger_if #(
  parameter int DATA_W = 32
);
  logic              debug_request;
  logic              core_reset_request;
  logic              core_halt_request;
  logic              core_busy;
  logic [DATA_W-1:0] debug_instruction;
  logic [DATA_W-1:0] debugger_result;
  logic              debugger_busy;
  logic              core_reset;
  logic              core_halt;

  modport master (
    input  debug_request, core_reset_request, core_halt_request, core_busy,
    input  debug_instruction,
    output debugger_result, debugger_busy, core_reset, core_halt
  );

  modport slave (
    output debug_request, core_reset_request, core_halt_request, core_busy,
    output debug_instruction,
    input  debugger_result, debugger_busy, core_reset, core_halt
  );
endinterface

// File: rtl/rv_debugger_decode.sv
// Combinational command-word decoder. A CTRL opcode takes priority over the
// REG funct field when both happen to match.
module rv_debugger_decode
  import rv_debugger_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] cmd,
  output logic              is_ctrl,
  output logic              is_reg,
  output logic              is_write,
  output logic [4:0]        reg_idx,
  output logic [3:0]        ctrl_code,
  output logic              illegal
);
  // Fields between the decoded ones carry no meaning for the controller.
  logic [8:0] unused_fields;
  assign unused_fields = {cmd[24:20], cmd[15:12]};

  always_comb begin
    is_ctrl   = (cmd[6:0] == OPC_CTRL);
    is_reg    = !is_ctrl && (cmd[31:25] == REG_FUNCT);
    is_write  = cmd[16];
    reg_idx   = cmd[11:7];
    ctrl_code = cmd[19:16];
    illegal   = !is_reg && !(is_ctrl && (ctrl_code <= CMD_HALT));
  end
endmodule

// File: rtl/rv_debugger.sv
// Debug controller: edge-qualified host commands drive core halt/reset and
// register access over a shared port. Define DEBUGGER_TIMEOUT_EN to bound WAIT/PUSH.
module rv_debugger
  import rv_debugger_pkg::*;
#(
  parameter int DATA_W             = 32,
  parameter int TIMEOUT_CYCLES     = 64,
  parameter int RESET_PULSE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  rv_debugger_if.master     bus,
  inout  wire  [DATA_W-1:0] debugger_port
);
  localparam int PW = $clog2(RESET_PULSE_CYCLES + 1);

  state_t            state, state_n;
  logic              req_q, accept, wr_q;
  logic              halt_flag, halt_flag_n;
  logic [PW-1:0]     pulse_cnt, pulse_cnt_n;
  logic [DATA_W-1:0] cmd_q, data_q, result_n, port_out;
  logic              result_ld, cmd_ld, data_ld, busy_n, port_en, timed_out;
  logic              is_ctrl, is_reg, is_write, illegal;
  logic [3:0]        ctrl_code;
  // The register index reaches the core inside the command word itself.
  logic [4:0]        unused_reg_idx;

  rv_debugger_decode #(.DATA_W(DATA_W)) u_decode (
    .cmd       (bus.debug_instruction),
    .is_ctrl   (is_ctrl),
    .is_reg    (is_reg),
    .is_write  (is_write),
    .reg_idx   (unused_reg_idx),
    .ctrl_code (ctrl_code),
    .illegal   (illegal)
  );

  assign accept        = bus.debug_request && !req_q && (state == IDLE);
  assign debugger_port = port_en ? port_out : {DATA_W{1'bz}};

`ifdef DEBUGGER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  assign timed_out = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               wait_cnt <= '0;
    else if (state == WAIT || state == PUSH) wait_cnt <= wait_cnt + 1'b1;
    else                                    wait_cnt <= '0;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    halt_flag_n = halt_flag;
    pulse_cnt_n = (pulse_cnt == '0) ? '0 : pulse_cnt - 1'b1;
    result_ld   = 1'b0;
    result_n    = '0;
    cmd_ld      = 1'b0;
    data_ld     = 1'b0;
    busy_n      = bus.debugger_busy;
    port_en     = 1'b0;
    port_out    = cmd_q;
    case (state)
      IDLE: if (accept) begin
        busy_n = 1'b1;
        cmd_ld = 1'b1;
        if (is_ctrl && !illegal) begin
          result_ld = 1'b1;
          state_n   = DONE;
          case (ctrl_code)
            CMD_HALT:   halt_flag_n = 1'b1;
            CMD_RESUME: halt_flag_n = 1'b0;
            CMD_RESET:  pulse_cnt_n = PW'(RESET_PULSE_CYCLES);
            default:    ;
          endcase
        end else if (is_reg && bus.core_halt) begin
          state_n = is_write ? DATA : DRIVE;
        end else begin
          result_ld = 1'b1;
          result_n  = ERR_ILLEGAL;
          state_n   = DONE;
        end
      end
      DATA: begin
        data_ld = 1'b1;
        state_n = DRIVE;
      end
      DRIVE: begin
        port_en = 1'b1;
        state_n = wr_q ? PUSH : WAIT;
      end
      WAIT: begin
        if (!bus.core_busy) begin
          state_n = CAPTURE;
        end else if (timed_out) begin
          result_ld = 1'b1;
          result_n  = ERR_TIMEOUT;
          state_n   = DONE;
        end
      end
      PUSH: begin
        port_en  = 1'b1;
        port_out = data_q;
        if (!bus.core_busy) begin
          result_ld = 1'b1;
          state_n   = DONE;
        end else if (timed_out) begin
          result_ld = 1'b1;
          result_n  = ERR_TIMEOUT;
          state_n   = DONE;
        end
      end
      CAPTURE: begin
        result_ld = 1'b1;
        result_n  = debugger_port;
        state_n   = DONE;
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      req_q               <= 1'b0;
      wr_q                <= 1'b0;
      halt_flag           <= 1'b0;
      pulse_cnt           <= '0;
      bus.debugger_busy   <= 1'b0;
      bus.debugger_result <= '0;
      bus.core_halt       <= 1'b0;
      bus.core_reset      <= 1'b0;
    end else begin
      state             <= state_n;
      req_q             <= bus.debug_request;
      halt_flag         <= halt_flag_n;
      pulse_cnt         <= pulse_cnt_n;
      bus.debugger_busy <= busy_n;
      bus.core_halt     <= bus.core_halt_request | halt_flag_n;
      bus.core_reset    <= bus.core_reset_request | (pulse_cnt_n != '0);
      if (cmd_ld)    wr_q                <= is_write;
      if (result_ld) bus.debugger_result <= result_n;
    end
  end

  // Command and write-data holding registers need no reset.
  always_ff @(posedge clk) begin
    if (cmd_ld)  cmd_q  <= bus.debug_instruction;
    if (data_ld) data_q <= bus.debug_instruction;
  end
endmodule

// File: tb/tb_rv_debugger.sv
// Self-checking bench for rv_debugger: directed scenarios plus randomized
// commands scored against a command-level reference model.
module tb_rv_debugger;
  localparam int          DW    = 32;
  localparam logic [31:0] PROBE = 32'hA5A5_5A5A;

  logic        clk;
  logic        rst;
  logic        core_en;
  logic [31:0] core_val;
  wire  [31:0] port_w;

  int checks   = 0;
  int failures = 0;

  logic        m_flag;
  logic [31:0] ports[$];

  rv_debugger_if #(.DATA_W(DW)) dif ();

  assign port_w = core_en ? core_val : {32{1'bz}};

  rv_debugger #(
    .DATA_W(DW), .TIMEOUT_CYCLES(64), .RESET_PULSE_CYCLES(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (dif),
    .debugger_port (port_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Issues one command and plays the core; returns busy length (-1 on hang).
  task automatic drive_cmd(input logic [31:0] cmd, input logic [31:0] wdata,
                           input int lat, input logic [31:0] rdata, output int cycles);
    logic is_rd;
    is_rd = (cmd[6:0] != 7'h0B) && (cmd[31:25] == 7'b0000001) && !cmd[16];
    ports.delete();
    dif.debug_instruction = cmd;
    dif.debug_request     = 1'b1;
    @(posedge clk); #1;
    dif.debug_request     = 1'b0;
    dif.debug_instruction = wdata;
    dif.core_busy         = 1'b1;
    cycles = 0;
    forever begin
      if (is_rd && cycles >= 1) begin
        core_en  = 1'b1;
        core_val = (cycles >= lat) ? rdata : PROBE;
      end
      if (cycles >= lat) dif.core_busy = 1'b0;
      @(negedge clk);
      if (dif.debugger_busy !== 1'b1) break;
      ports.push_back(port_w);
      cycles++;
      if (cycles > 300) begin
        cycles = -1;
        break;
      end
      @(posedge clk); #1;
    end
    core_en       = 1'b0;
    dif.core_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    core_en = 1'b1; core_val = PROBE;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dif.debugger_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", dif.debugger_busy); end
    checks++; if (dif.debugger_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", dif.debugger_result); end
    checks++; if (dif.core_reset !== 1'b0) begin failures++; $display("FAIL reset_core_reset got=%b exp=0", dif.core_reset); end
    checks++; if (dif.core_halt !== 1'b0) begin failures++; $display("FAIL reset_core_halt got=%b exp=0", dif.core_halt); end
    checks++; if (port_w !== PROBE) begin failures++; $display("FAIL reset_port got=%h exp=%h", port_w, PROBE); end
    @(negedge clk);
    rst = 1'b1; core_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (dif.debugger_busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", dif.debugger_busy); end
    m_flag = 1'b0;
  endtask

  task automatic test_halt();
    int cyc;
    dif.debug_instruction = 32'h0003_000B;
    dif.debug_request     = 1'b1;
    @(posedge clk); #1;
    checks++; if (dif.core_halt !== 1'b1) begin failures++; $display("FAIL halt_core_halt got=%b exp=1", dif.core_halt); end
    checks++; if (dif.debugger_busy !== 1'b1) begin failures++; $display("FAIL halt_busy_rise got=%b exp=1", dif.debugger_busy); end
    @(posedge clk); #1;
    dif.debug_request = 1'b0;
    checks++; if (dif.debugger_busy !== 1'b0) begin failures++; $display("FAIL halt_busy_fall got=%b exp=0", dif.debugger_busy); end
    checks++; if (dif.debugger_result !== 32'h0) begin failures++; $display("FAIL halt_result got=%h exp=0", dif.debugger_result); end
    @(posedge clk); #1;
    checks++; if (dif.debugger_busy !== 1'b0) begin failures++; $display("FAIL halt_single got=%b exp=0", dif.debugger_busy); end
    m_flag = 1'b1;
    drive_cmd(32'h0002_000B, 32'h0, 0, 32'h0, cyc);
    m_flag = 1'b0;
    checks++; if (dif.core_halt !== 1'b0) begin failures++; $display("FAIL resume_core_halt got=%b exp=0", dif.core_halt); end
    checks++; if (cyc != 1) begin failures++; $display("FAIL resume_busy_len got=%0d exp=1", cyc); end
  endtask

  task automatic test_read();
    int cyc;
    dif.core_halt_request = 1'b1;
    @(posedge clk); #1;
    drive_cmd(32'h0200_0000, 32'h0, 3, 32'h0000_00FF, cyc);
    checks++; if (dif.debugger_result !== 32'h0000_00FF) begin failures++; $display("FAIL read_result got=%h exp=000000ff", dif.debugger_result); end
    checks++; if (cyc != 6) begin failures++; $display("FAIL read_busy_len got=%0d exp=6", cyc); end
    checks++; if (ports.size() < 2 || ports[0] !== 32'h0200_0000) begin failures++; $display("FAIL read_port_cmd got=%h exp=02000000", (ports.size() > 0) ? ports[0] : 32'hx); end
    checks++; if (ports.size() < 2 || ports[1] !== PROBE) begin failures++; $display("FAIL read_port_released got=%h exp=%h", (ports.size() > 1) ? ports[1] : 32'hx, PROBE); end
  endtask

  task automatic test_write();
    int cyc;
    drive_cmd(32'h0201_0000, 32'h00C0_0001, 4, 32'h0, cyc);
    checks++; if (dif.debugger_result !== 32'h0) begin failures++; $display("FAIL write_result got=%h exp=0", dif.debugger_result); end
    checks++; if (cyc != 6) begin failures++; $display("FAIL write_busy_len got=%0d exp=6", cyc); end
    checks++; if (ports.size() < 5 || ports[1] !== 32'h0201_0000) begin failures++; $display("FAIL write_port_cmd got=%h exp=02010000", (ports.size() > 1) ? ports[1] : 32'hx); end
    checks++; if (ports.size() < 5 || ports[2] !== 32'h00C0_0001) begin failures++; $display("FAIL write_port_data got=%h exp=00c00001", (ports.size() > 2) ? ports[2] : 32'hx); end
    checks++; if (ports.size() < 5 || ports[4] !== 32'h00C0_0001) begin failures++; $display("FAIL write_port_hold got=%h exp=00c00001", (ports.size() > 4) ? ports[4] : 32'hx); end
    dif.core_halt_request = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_error();
    int cyc;
    drive_cmd(32'h0200_0000, 32'h0, 2, 32'h1234_5678, cyc);
    checks++; if (dif.debugger_result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL err_unhalted_read got=%h exp=ffffffff", dif.debugger_result); end
    checks++; if (cyc != 1) begin failures++; $display("FAIL err_busy_len got=%0d exp=1", cyc); end
    drive_cmd(32'h0000_000B, 32'h0, 0, 32'h0, cyc);
    checks++; if (dif.debugger_result !== 32'h0) begin failures++; $display("FAIL nop_result got=%h exp=0", dif.debugger_result); end
    drive_cmd(32'h0000_0003, 32'h0, 0, 32'h0, cyc);
    checks++; if (dif.debugger_result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL err_opcode got=%h exp=ffffffff", dif.debugger_result); end
    drive_cmd(32'h0000_000B, 32'h0, 0, 32'h0, cyc);
    drive_cmd(32'h0005_000B, 32'h0, 0, 32'h0, cyc);
    checks++; if (dif.debugger_result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL err_ctrl_code got=%h exp=ffffffff", dif.debugger_result); end
  endtask

  task automatic test_held_request();
    int   rises;
    logic prev;
    rises = 0;
    prev  = dif.debugger_busy;
    dif.debug_instruction = 32'h0000_000B;
    dif.debug_request     = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (dif.debugger_busy === 1'b1 && prev !== 1'b1) rises++;
      prev = dif.debugger_busy;
    end
    dif.debug_request = 1'b0;
    checks++; if (rises != 1) begin failures++; $display("FAIL held_request_cmds got=%0d exp=1", rises); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_cmd();
    int cyc;
    int hi;
    drive_cmd(32'h0003_000B, 32'h0, 0, 32'h0, cyc);
    m_flag = 1'b1;
    dif.debug_instruction = 32'h0001_000B;
    dif.debug_request     = 1'b1;
    @(posedge clk); #1;
    dif.debug_request = 1'b0;
    hi = (dif.core_reset === 1'b1) ? 1 : 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (dif.core_reset === 1'b1) hi++;
    end
    checks++; if (hi != 2) begin failures++; $display("FAIL reset_pulse_len got=%0d exp=2", hi); end
    checks++; if (dif.core_halt !== 1'b1) begin failures++; $display("FAIL reset_keeps_halt got=%b exp=1", dif.core_halt); end
    dif.core_reset_request = 1'b1;
    @(posedge clk); #1;
    checks++; if (dif.core_reset !== 1'b1) begin failures++; $display("FAIL direct_reset got=%b exp=1", dif.core_reset); end
    dif.core_reset_request = 1'b0;
    @(posedge clk); #1;
    checks++; if (dif.core_reset !== 1'b0) begin failures++; $display("FAIL direct_reset_off got=%b exp=0", dif.core_reset); end
  endtask

  task automatic test_rst_mid_wait();
    int cyc;
    dif.debug_instruction = 32'h0200_0000;
    dif.debug_request     = 1'b1;
    @(posedge clk); #1;
    dif.debug_request = 1'b0;
    dif.core_busy     = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    core_en = 1'b1; core_val = PROBE;
    rst = 1'b0;
    #1;
    checks++; if (dif.debugger_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", dif.debugger_busy); end
    checks++; if (dif.core_halt !== 1'b0) begin failures++; $display("FAIL midrst_halt got=%b exp=0", dif.core_halt); end
    checks++; if (port_w !== PROBE) begin failures++; $display("FAIL midrst_port got=%h exp=%h", port_w, PROBE); end
    @(negedge clk);
    rst = 1'b1; core_en = 1'b0; dif.core_busy = 1'b0;
    m_flag = 1'b0;
    drive_cmd(32'h0000_000B, 32'h0, 0, 32'h0, cyc);
    checks++; if (cyc != 1) begin failures++; $display("FAIL midrst_idle_after got=%0d exp=1", cyc); end
  endtask

  task automatic test_halt_race();
    int cyc;
    dif.core_halt_request = 1'b1;
    @(posedge clk); #1;
    dif.core_halt_request = 1'b0;
    dif.debug_instruction = 32'h0003_000B;
    dif.debug_request     = 1'b1;
    @(posedge clk); #1;
    dif.debug_request = 1'b0;
    checks++; if (dif.core_halt !== 1'b1) begin failures++; $display("FAIL race_halt got=%b exp=1", dif.core_halt); end
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (dif.core_halt !== 1'b1) begin failures++; $display("FAIL race_halt_hold got=%b exp=1", dif.core_halt); end
    drive_cmd(32'h0002_000B, 32'h0, 0, 32'h0, cyc);
    m_flag = 1'b0;
  endtask

  task automatic test_random();
    int          cyc, lat, exp_cyc, kind;
    logic        chr, halted;
    logic [31:0] c, rdata, wdata, exp_res;
    for (int i = 0; i < 40; i++) begin
      chr = 1'($urandom_range(0, 1));
      dif.core_halt_request = chr;
      @(posedge clk); #1;
      halted = m_flag | chr;
      kind  = $urandom_range(0, 3);
      lat   = $urandom_range(1, 5);
      rdata = $urandom;
      wdata = $urandom;
      c     = $urandom;
      if (kind == 0) begin
        c[6:0] = 7'h0B; c[19:16] = 4'($urandom_range(0, 5));
      end else if (kind == 3) begin
        if (c[6:0] == 7'h0B) c[6:0] = 7'h0C;
        if (c[31:25] == 7'b0000001) c[31:25] = 7'b0000010;
      end else begin
        c[31:25] = 7'b0000001;
        if (c[6:0] == 7'h0B) c[6:0] = 7'h0C;
      end
      exp_res = 32'hFFFF_FFFF;
      exp_cyc = 1;
      if (c[6:0] == 7'h0B) begin
        if (c[19:16] <= 4'd3) exp_res = 32'h0;
        if (c[19:16] == 4'd3) m_flag = 1'b1;
        if (c[19:16] == 4'd2) m_flag = 1'b0;
      end else if (c[31:25] == 7'b0000001 && halted) begin
        if (c[16]) begin
          exp_res = 32'h0;
          exp_cyc = 3 + ((lat > 2) ? lat - 1 : 1);
        end else begin
          exp_res = rdata;
          exp_cyc = lat + 3;
        end
      end
      drive_cmd(c, wdata, lat, rdata, cyc);
      checks++; if (dif.debugger_result !== exp_res) begin failures++; $display("FAIL rand_result[%0d] cmd=%h got=%h exp=%h", i, c, dif.debugger_result, exp_res); end
      checks++; if (cyc != exp_cyc) begin failures++; $display("FAIL rand_busy_len[%0d] cmd=%h got=%0d exp=%0d", i, c, cyc, exp_cyc); end
      checks++; if (dif.core_halt !== (m_flag | chr)) begin failures++; $display("FAIL rand_core_halt[%0d] cmd=%h got=%b exp=%b", i, c, dif.core_halt, m_flag | chr); end
    end
    dif.core_halt_request = 1'b0;
  endtask

  initial begin
    rst                    = 1'b1;
    core_en                = 1'b0;
    core_val               = 32'h0;
    m_flag                 = 1'b0;
    dif.debug_request      = 1'b0;
    dif.core_reset_request = 1'b0;
    dif.core_halt_request  = 1'b0;
    dif.core_busy          = 1'b0;
    dif.debug_instruction  = 32'h0;
    #2;
    test_reset();
    test_halt();
    test_read();
    test_write();
    test_error();
    test_held_request();
    test_reset_cmd();
    test_rst_mid_wait();
    test_halt_race();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv_debugger.md
Name: rv_debugger

Overview:
- Debug controller between the host-side debug module interface and the RISC-V core.
- Accepts 32-bit debug commands with a request strobe and controls core halt and reset.
- Performs register reads and writes through a shared 32-bit port to the core, using the core busy handshake.
- Returns read data or status on debugger_result and flags activity on debugger_busy.

Parameters:
- DATA_W, 32, width of command, data, port and result.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for core_busy to fall (used only with the optional feature).
- RESET_PULSE_CYCLES, 2, length of the command-generated core_reset pulse.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; one clock, asynchronous, active-low (rst=0 resets).
- debug_request  in  1  command strobe; level, edge-qualified internally.
- core_reset_request  in  1  host direct reset request.
- core_halt_request  in  1  host direct halt request.
- core_busy  in  1  core is servicing a port access.
- debug_instruction  in  DATA_W  command word; in the cycle after request, the write data.
- debugger_port  inout  DATA_W  driven by debugger during command/data phases, else Z; core drives read data.
- debugger_result  out  DATA_W  read data or status.
- debugger_busy  out  1  command in progress.
- core_reset  out  1  reset to core, active-high.
- core_halt  out  1  halt to core, active-high.

Behaviour:
- Reset: debugger_busy=0, debugger_result=0, core_reset=0, core_halt=0, halt_flag=0, state=IDLE, debugger_port=Z.
- Acceptance: a command is accepted on a clk edge when debug_request=1, its previous sampled value was 0, and state=IDLE.
  - Held-high requests issue only one command.
  - Requests arriving while busy are dropped.
- debugger_busy is registered and goes to 1 the cycle after acceptance.
- CTRL command: opcode [6:0]=7'h0B, code [19:16].
  - 3 = HALT: halt_flag<=1.
  - 2 = RESUME: halt_flag<=0.
  - 1 = RESET: core_reset pulses for RESET_PULSE_CYCLES.
  - 0 = NOP.
  - Other codes are ERR.
  - Completes in 1 cycle; result=32'h0000_0000.
- REG command: [31:25]=7'b0000001, [16]=write, [11:7]=register index. Legal only when core_halt=1, else ERR.
  - Read: DRIVE (port=command word, 1 cycle) -> WAIT (port=Z until core_busy=0, min 1 cycle) -> CAPTURE (result<=debugger_port) -> DONE.
  - Write: DATA (sample debug_instruction as data in the cycle after acceptance) -> DRIVE (port=command, 1 cycle) -> PUSH (port=data until core_busy=0) -> DONE, result=0.
- Any other encoding is ERR: result=32'hFFFF_FFFF, 1 cycle.
- DONE: busy<=0, return to IDLE. debugger_result holds its value until the next command completes.
- Registered outputs:
  - core_halt = core_halt_request | halt_flag.
  - core_reset = core_reset_request | pulse_active.
- Simultaneous core_halt_request fall and HALT command: halt_flag wins, so core_halt stays 1.
- RESET command while halted: halt_flag is kept.
- rst asserted mid-operation: immediate return to the reset values; port released to Z.

Optional Feature:
- Macro DEBUGGER_TIMEOUT_EN.
- Defined: a counter limits WAIT/PUSH to TIMEOUT_CYCLES. On expiry, result=32'hFFFF_FFFE, port released, DONE.
- Undefined: wait indefinitely for core_busy=0.

Decomposition:
- Package rv_debugger_pkg holds:
  - OPC_CTRL=7'h0B and REG_FUNCT=7'b0000001.
  - CMD_NOP/RESET/RESUME/HALT codes.
  - ERR_ILLEGAL=32'hFFFF_FFFF and ERR_TIMEOUT=32'hFFFF_FFFE.
  - State enum IDLE/DATA/DRIVE/WAIT/PUSH/CAPTURE/DONE.
- One combinational sub-module, rv_debugger_decode: maps the command word to {is_ctrl, is_reg, is_write, reg_idx, ctrl_code, illegal}.

Test Plan:
- Reset: rst=0 -> all outputs 0 and port Z; after release, busy=0.
- HALT: request 2 cycles with 32'h0003000B -> one command; core_halt=1 next cycle; busy high 1 cycle; result=0. Then 32'h0002000B with core_halt_request=0 -> core_halt=0.
- Read while halted: 32'h02000000, core holds busy 3 cycles then drives 32'h0000_00FF -> result=32'h0000_00FF; busy falls the cycle after capture.
- Write while halted: 32'h02010000 then data 32'h00C00001 -> port carries command then 32'h00C00001 until core_busy=0; result=0.
- Error: read while not halted, or 32'h00000003 -> result=32'hFFFF_FFFF. Request held high 10 cycles -> exactly one command.
- Reset command: 32'h0001000B -> core_reset high exactly 2 cycles. Also core_reset_request=1 -> core_reset=1 next cycle; rst mid-WAIT -> state IDLE, port Z.
